// File: rtl/fibergyro_pkg.sv
// Shared constants, state encoding and small arithmetic helpers for the
// fiber-gyro poll scheduler.
package fibergyro_pkg;

  localparam logic [7:0] CMD_HDR_DEF  = 8'hAA;
  localparam logic [7:0] CMD_CODE_DEF = 8'h55;
  localparam logic [7:0] RESP_HDR     = 8'h80;
  localparam int         RESP_LEN     = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND0   = 3'd1;
  localparam logic [2:0] S_SEND1   = 3'd2;
  localparam logic [2:0] S_RX_HDR  = 3'd3;
  localparam logic [2:0] S_RX_DATA = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_SEND0   = S_SEND0,
    ST_SEND1   = S_SEND1,
    ST_RX_HDR  = S_RX_HDR,
    ST_RX_DATA = S_RX_DATA,
    ST_CHECK   = S_CHECK
  } state_t;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fibergyro_rx_framer.sv
// Response framer: hunts for the header byte, accumulates the 8-bit checksum and
// shifts the six payload bytes into a 48-bit buffer.
module fibergyro_rx_framer
  import fibergyro_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  rx_byte,
  output logic        synced,
  output logic        frame_done,
  output logic        cksum_ok,
  output logic [47:0] data
);

  logic [2:0]  idx_r;
  logic [7:0]  sum_r;
  logic [47:0] buf_r;
  logic        done_r;
  logic        ok_r;

  // Byte index 0 means still hunting for the header; the last byte is the checksum.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx_r  <= 3'd0;
      sum_r  <= 8'd0;
      buf_r  <= 48'd0;
      done_r <= 1'b0;
      ok_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (clr) begin
        idx_r <= 3'd0;
        sum_r <= 8'd0;
        buf_r <= 48'd0;
        ok_r  <= 1'b0;
      end else if (byte_vld) begin
        if (idx_r == 3'd0) begin
          if (rx_byte == RESP_HDR) begin
            sum_r <= rx_byte;
            idx_r <= 3'd1;
          end
        end else if (idx_r == 3'(RESP_LEN - 1)) begin
          ok_r   <= (rx_byte == sum_r);
          done_r <= 1'b1;
          idx_r  <= 3'd0;
        end else begin
          sum_r <= sum8(sum_r, rx_byte);
          buf_r <= {buf_r[39:0], rx_byte};
          idx_r <= idx_r + 3'd1;
        end
      end
    end
  end

  assign synced     = (idx_r != 3'd0);
  assign frame_done = done_r;
  assign cksum_ok   = ok_r;
  assign data       = buf_r;

endmodule

// File: rtl/fibergyro_poll_sched.sv
// Autonomous poll scheduler: periodically writes a 2-byte command to the UART core,
// collects the 8-byte gyro response and publishes validated rate words.
module fibergyro_poll_sched
  import fibergyro_pkg::*;
#(
  parameter int         POLL_DIV = 100000,
  parameter int         TIMEOUT  = 20000,
  parameter logic [7:0] CMD_HDR  = CMD_HDR_DEF,
  parameter logic [7:0] CMD_CODE = CMD_CODE_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        poll_en,
  input  logic        TXrd,
  input  logic        RXrd,
  input  logic [7:0]  RX,
  output logic [7:0]  TX_data,
  output logic        WEN,
  output logic        OEN,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        frame_valid,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  localparam logic [31:0] POLL_LAST = 32'(POLL_DIV - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

  state_t      state_r;
  logic [1:0]  tx_ph_r;
  logic [31:0] poll_tmr_r;
  logic [31:0] to_cnt_r;
  logic        poll_req_r;
  logic        rx_vld_r;

  logic        wrap_s, start_s, in_rx_s, rd_busy_s, byte_vld_s;
  logic        timeout_s, strobe_s, clr_s;
  logic        synced_s, frame_done_s, cksum_ok_s;
  logic [47:0] data_s;

  assign wrap_s     = poll_en && (poll_tmr_r == POLL_LAST);
  assign start_s    = (state_r == ST_IDLE) && poll_en && (poll_req_r || wrap_s);
  assign in_rx_s    = (state_r == ST_RX_HDR) || (state_r == ST_RX_DATA);
  assign rd_busy_s  = !OEN || rx_vld_r;
  assign byte_vld_s = rx_vld_r && in_rx_s;
  // A read already in flight will capture a byte, so it beats the timeout.
  assign timeout_s  = in_rx_s && (to_cnt_r == TO_LAST) && !rd_busy_s;
  assign strobe_s   = in_rx_s && RXrd && !rd_busy_s && !timeout_s && !frame_done_s;
  assign clr_s      = (state_r == ST_SEND1) && (tx_ph_r == 2'd2);

  fibergyro_rx_framer u_framer (
    .CLK        (CLK),
    .RESET      (RESET),
    .clr        (clr_s),
    .byte_vld   (byte_vld_s),
    .rx_byte    (RX),
    .synced     (synced_s),
    .frame_done (frame_done_s),
    .cksum_ok   (cksum_ok_s),
    .data       (data_s)
  );

  // Sequencer, poll timer, timeout counter and all registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      tx_ph_r     <= 2'd0;
      poll_tmr_r  <= 32'd0;
      to_cnt_r    <= 32'd0;
      poll_req_r  <= 1'b0;
      rx_vld_r    <= 1'b0;
      TX_data     <= 8'd0;
      WEN         <= 1'b1;
      OEN         <= 1'b1;
      gyro_x      <= 16'd0;
      gyro_y      <= 16'd0;
      gyro_z      <= 16'd0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= 16'd0;
      err_cnt     <= 8'd0;
    end else begin
      WEN         <= 1'b1;
      OEN         <= ~strobe_s;
      rx_vld_r    <= ~OEN;
      frame_valid <= 1'b0;

      if (!poll_en || wrap_s) poll_tmr_r <= 32'd0;
      else                    poll_tmr_r <= poll_tmr_r + 32'd1;

      if (start_s)     poll_req_r <= 1'b0;
      else if (wrap_s) poll_req_r <= 1'b1;

      if (!in_rx_s)                to_cnt_r <= 32'd0;
      else if (byte_vld_s)         to_cnt_r <= 32'd0;
      else if (to_cnt_r != TO_LAST) to_cnt_r <= to_cnt_r + 32'd1;

      case (state_r)
        ST_IDLE: begin
          // The start cycle doubles as the first SEND0 cycle so the strobe is not delayed.
          if (start_s) begin
            state_r <= ST_SEND0;
            busy    <= 1'b1;
            TX_data <= CMD_HDR;
            if (TXrd) begin
              WEN     <= 1'b0;
              tx_ph_r <= 2'd1;
            end else begin
              tx_ph_r <= 2'd0;
            end
          end
        end
        ST_SEND0, ST_SEND1: begin
          case (tx_ph_r)
            2'd0: begin
              if (TXrd) begin
                WEN     <= 1'b0;
                tx_ph_r <= 2'd1;
              end
            end
            2'd1: tx_ph_r <= 2'd2;
            2'd2: begin
              tx_ph_r <= 2'd0;
              if (state_r == ST_SEND0) begin
                state_r <= ST_SEND1;
                TX_data <= CMD_CODE;
              end else begin
                state_r <= ST_RX_HDR;
              end
            end
            default: tx_ph_r <= 2'd0;
          endcase
        end
        ST_RX_HDR, ST_RX_DATA: begin
          if (timeout_s) begin
            err_cnt <= sat_inc8(err_cnt);
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else if (state_r == ST_RX_HDR && synced_s) begin
            state_r <= ST_RX_DATA;
          end else if (state_r == ST_RX_DATA && frame_done_s) begin
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cksum_ok_s) begin
            gyro_x      <= data_s[47:32];
            gyro_y      <= data_s[31:16];
            gyro_z      <= data_s[15:0];
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
          end else begin
            err_cnt <= sat_inc8(err_cnt);
          end
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibergyro_poll_sched.sv
// Directed self-checking bench for fibergyro_poll_sched with a short poll period
// and timeout; a small UART-core model answers OEN strobes with frame bytes.
module tb_fibergyro_poll_sched;

  localparam int POLL_DIV = 64;
  localparam int TIMEOUT  = 32;

  logic        CLK = 1'b0;
  logic        RESET, poll_en, TXrd, RXrd;
  logic [7:0]  RX;
  logic [7:0]  TX_data, err_cnt;
  logic        WEN, OEN, frame_valid, busy;
  logic [15:0] gyro_x, gyro_y, gyro_z, frame_cnt;

  int checks = 0;
  int passes = 0;

  fibergyro_poll_sched #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .poll_en(poll_en), .TXrd(TXrd), .RXrd(RXrd), .RX(RX),
    .TX_data(TX_data), .WEN(WEN), .OEN(OEN), .gyro_x(gyro_x), .gyro_y(gyro_y),
    .gyro_z(gyro_z), .frame_valid(frame_valid), .busy(busy), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  // Waits for the two command strobes; n returns the cycle of the first one.
  task automatic wait_cmd(input int budget, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge CLK); #1;
      if (WEN === 1'b0) begin n = i; got = 1'b1; break; end
    end
    checks++;
    if (!got) $display("FAIL cmd_strobe0: WEN stayed %b, required 0 within %0d cycles", WEN, budget);
    else passes++;
    checks++;
    if (TX_data !== 8'hAA) $display("FAIL cmd_byte0: TX_data=%h, required AA", TX_data);
    else passes++;
    @(posedge CLK); #1;
    checks++;
    if (WEN !== 1'b1) $display("FAIL cmd_width0: WEN=%b one cycle later, required 1", WEN);
    else passes++;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (WEN === 1'b0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || TX_data !== 8'h55) $display("FAIL cmd_byte1: WEN=%b TX_data=%h, required 0 and 55", WEN, TX_data);
    else passes++;
    @(posedge CLK); #1;
    checks++;
    if (WEN !== 1'b1) $display("FAIL cmd_width1: WEN=%b one cycle later, required 1", WEN);
    else passes++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    RXrd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (OEN === 1'b0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) $display("FAIL rx_strobe: OEN=%b, required 0 for byte %h", OEN, b);
    else passes++;
    RX = b;
    RXrd = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (OEN !== 1'b1) $display("FAIL rx_strobe_width: OEN=%b, required 1", OEN);
    else passes++;
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic count_fv(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      if (frame_valid === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; poll_en = 1'b1; TXrd = 1'b1; RXrd = 1'b0; RX = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({WEN, OEN, frame_valid, busy} !== 4'b1100)
      $display("FAIL reset_ctrl: WEN/OEN/fv/busy=%b, required 1100", {WEN, OEN, frame_valid, busy});
    else passes++;
    checks++;
    if ({TX_data, gyro_x, gyro_y, gyro_z, frame_cnt, err_cnt} !== 88'd0)
      $display("FAIL reset_data: tx=%h gyro=%h/%h/%h fc=%h ec=%h, required all 0",
               TX_data, gyro_x, gyro_y, gyro_z, frame_cnt, err_cnt);
    else passes++;
  endtask

  task automatic test_poll_tx();
    int n;
    @(negedge CLK);
    RESET = 1'b0;
    wait_cmd(100, n);
    checks++;
    if (n != 64) $display("FAIL first_poll_cycle: got %0d, required 64", n);
    else passes++;
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_in_send: busy=%b, required 1", busy);
    else passes++;
  endtask

  task automatic test_good_frame();
    int fv;
    send_frame(64'h8001020304050695);
    count_fv(10, fv);
    checks++;
    if (fv != 1) $display("FAIL good_fv: %0d pulses, required 1", fv);
    else passes++;
    checks++;
    if ({gyro_x, gyro_y, gyro_z} !== 48'h010203040506)
      $display("FAIL good_gyro: %h %h %h, required 0102 0304 0506", gyro_x, gyro_y, gyro_z);
    else passes++;
    checks++;
    if (frame_cnt !== 16'd1 || err_cnt !== 8'd0)
      $display("FAIL good_counts: fc=%0d ec=%0d, required 1 and 0", frame_cnt, err_cnt);
    else passes++;
  endtask

  task automatic test_bad_cksum();
    int n, fv;
    wait_cmd(200, n);
    send_frame(64'h8001020304050696);
    count_fv(10, fv);
    checks++;
    if (fv != 0) $display("FAIL bad_fv: %0d pulses, required 0", fv);
    else passes++;
    checks++;
    if (err_cnt !== 8'd1 || frame_cnt !== 16'd1)
      $display("FAIL bad_counts: ec=%0d fc=%0d, required 1 and 1", err_cnt, frame_cnt);
    else passes++;
    checks++;
    if ({gyro_x, gyro_y, gyro_z} !== 48'h010203040506)
      $display("FAIL bad_gyro_kept: %h %h %h, required 0102 0304 0506", gyro_x, gyro_y, gyro_z);
    else passes++;
  endtask

  task automatic test_resync();
    int n, fv;
    wait_cmd(200, n);
    send_byte(8'h3C);
    send_frame(64'h8001020304050695);
    count_fv(10, fv);
    checks++;
    if (fv != 1 || frame_cnt !== 16'd2 || err_cnt !== 8'd1)
      $display("FAIL resync: fv=%0d fc=%0d ec=%0d, required 1 2 1", fv, frame_cnt, err_cnt);
    else passes++;
  endtask

  task automatic test_timeout();
    int n, fv;
    bit got;
    wait_cmd(200, n);
    send_byte(8'h80); send_byte(8'h11); send_byte(8'h22);
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge CLK); #1;
      if (err_cnt === 8'd2) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) $display("FAIL timeout_err: ec=%0d, required 2", err_cnt);
    else passes++;
    checks++;
    if ({busy, WEN, OEN} !== 3'b011) $display("FAIL timeout_idle: busy/WEN/OEN=%b, required 011", {busy, WEN, OEN});
    else passes++;
    wait_cmd(200, n);
    send_frame(64'h800A0B0C0D0E0FCB);
    count_fv(10, fv);
    checks++;
    if (fv != 1 || {gyro_x, gyro_y, gyro_z} !== 48'h0A0B0C0D0E0F || frame_cnt !== 16'd3)
      $display("FAIL after_timeout: fv=%0d gyro=%h %h %h fc=%0d, required 1 0A0B 0C0D 0E0F 3",
               fv, gyro_x, gyro_y, gyro_z, frame_cnt);
    else passes++;
  endtask

  task automatic test_poll_en_stop();
    int n, fv, lows;
    wait_cmd(200, n);
    poll_en = 1'b0;
    send_frame(64'h80001000200030E0);
    count_fv(10, fv);
    checks++;
    if (fv != 1 || gyro_x !== 16'h0010 || gyro_z !== 16'h0030 || frame_cnt !== 16'd4)
      $display("FAIL stop_completes: fv=%0d x=%h z=%h fc=%0d, required 1 0010 0030 4", fv, gyro_x, gyro_z, frame_cnt);
    else passes++;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge CLK); #1;
      if (WEN === 1'b0) lows++;
    end
    checks++;
    if (lows != 0 || busy !== 1'b0) $display("FAIL stop_no_poll: %0d strobes busy=%b, required 0 and 0", lows, busy);
    else passes++;
    poll_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    wait_cmd(200, n);
    send_byte(8'h80); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({WEN, OEN, frame_valid, busy} !== 4'b1100)
      $display("FAIL midreset_ctrl: WEN/OEN/fv/busy=%b, required 1100", {WEN, OEN, frame_valid, busy});
    else passes++;
    checks++;
    if ({TX_data, gyro_x, gyro_y, gyro_z, frame_cnt, err_cnt} !== 88'd0)
      $display("FAIL midreset_data: tx=%h gyro=%h/%h/%h fc=%h ec=%h, required all 0",
               TX_data, gyro_x, gyro_y, gyro_z, frame_cnt, err_cnt);
    else passes++;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_poll_tx();
    test_good_frame();
    test_bad_cksum();
    test_resync();
    test_timeout();
    test_poll_en_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
